arbiter_requester: RTL and testbench
====================================

ARBITER_REQUESTER -- requirements
Module: arbiter_requester

Interface
REQ-001 Parameter DATA_W, default 8, width of bus_data and cmd_data.
REQ-002 Parameter FIFO_DEPTH, default 4, number of queued commands (power of 2).
REQ-003 Parameter TIMEOUT, default 15, max cycles REQ is held waiting for first grant.
REQ-004 Parameter GAP, default 2, cycles REQ is held low between transactions.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 cmd_valid  input  1  command offered.
REQ-008 cmd_ready  output  1  command accepted this cycle when high with cmd_valid.
REQ-009 cmd_len  input  4  burst length minus one (beats = cmd_len+1, 1..16).
REQ-010 cmd_data  input  DATA_W  base data value of burst.
REQ-011 REQ  output  1  request line to one input of the fixed-priority arbiter.
REQ-012 GNT  input  1  this agent's grant bit from the arbiter (registered there, may drop at any cycle).
REQ-013 bus_valid  output  1  beat on bus this cycle.
REQ-014 bus_data  output  DATA_W  beat payload.
REQ-015 done  output  1  one-cycle pulse with final beat of a burst.
REQ-016 timeout_err  output  1  one-cycle pulse when a command is aborted for no grant.
REQ-017 busy  output  1  high whenever state is not IDLE or FIFO non-empty.

Function
REQ-018 Command FIFO SHALL store {cmd_len, cmd_data}; cmd_ready = not full; push on cmd_valid & cmd_ready; full FIFO SHALL refuse push even if a pop occurs that cycle.
REQ-019 FSM states SHALL be IDLE, REQ_WAIT, XFER, GAP.
REQ-020 IDLE: REQ=0; if FIFO non-empty, pop head into working regs (len, base, beat_idx=0, wait_cnt=0) and go REQ_WAIT next cycle.
REQ-021 REQ_WAIT: REQ=1; GNT=1 -> XFER next cycle, no beat issued in this cycle.
REQ-022 REQ_WAIT with GNT=0: wait_cnt increments; when GNT=0 on the cycle wait_cnt==TIMEOUT-1, pulse timeout_err, discard command, go GAP (REQ high exactly TIMEOUT cycles).
REQ-023 XFER: REQ=1; bus_valid = GNT (combinational from state and GNT); bus_data = (base + beat_idx) mod 2^DATA_W.
REQ-024 XFER with GNT=1: beat_idx increments; when beat_idx==len, done pulses that cycle and state goes GAP.
REQ-025 XFER with GNT=0 (pre-empted by higher priority): bus_valid=0, beat_idx holds, REQ stays 1, no timeout, resume on next GNT=1.
REQ-026 GAP: REQ=0 for exactly GAP cycles, then IDLE; GAP=0 SHALL go straight to IDLE.
REQ-027 GNT while in IDLE or GAP SHALL be ignored (no beat, no state change).
REQ-028 A command pushed while FIFO empty and IDLE SHALL cause REQ=1 no earlier than 2 cycles after the push edge.
REQ-029 done and timeout_err SHALL never assert in the same cycle.

Reset
REQ-030 reset=1 at a clock edge SHALL force IDLE, FIFO empty, all counters 0.
REQ-031 During and after reset: REQ=0, bus_valid=0, bus_data=0, done=0, timeout_err=0, busy=0, cmd_ready=1.
REQ-032 reset mid-burst SHALL drop REQ and bus_valid at the next edge and discard in-flight and queued commands.

Verification
REQ-033 Push len=3, data=0x10, GNT follows REQ one cycle later -> REQ rises, 4 consecutive beats 0x10,0x11,0x12,0x13, done with 0x13, REQ low 2 cycles.
REQ-034 Same command, GNT dropped for 3 cycles after beat 2 -> bus_valid low 3 cycles, REQ stays 1, beats resume 0x12,0x13, no timeout.
REQ-035 Push len=0, GNT tied 0 -> REQ high exactly 15 cycles, timeout_err pulse once, no bus_valid, then REQ low 2 cycles, IDLE.
REQ-036 Push 5 commands back-to-back -> cmd_ready low on 5th when 4 queued (no pop yet), all accepted commands executed in order.
REQ-037 base=0xFE, len=3 -> beats 0xFE,0xFF,0x00,0x01 (wrap).
REQ-038 Assert reset during beat 2 of a queued 3-command sequence -> REQ=0, bus_valid=0 next cycle, busy=0, no further beats after release.

Source files
------------

// File: rtl/arbiter_requester.sv
`default_nettype none
// ============================================================================
// Module   : arbiter_requester
// Purpose  : Bus-master side of a fixed-priority arbiter. Commands (burst
//            length + base data) are queued in a small FIFO, then each one is
//            executed by raising REQ, waiting for GNT and issuing beats of
//            base, base+1, ... while GNT is held. A command that never sees a
//            grant within TIMEOUT cycles is dropped with a timeout_err pulse.
//            REQ is released for GAP cycles between transactions.
//
// Ports    : clk          in   clock, rising-edge active
//            reset        in   synchronous active-high reset
//            cmd_valid    in   command offered
//            cmd_ready    out  FIFO can take a command (not full)
//            cmd_len      in   [3:0] beats minus one
//            cmd_data     in   [DATA_W-1:0] base value of the burst
//            REQ          out  request to the arbiter
//            GNT          in   grant from the arbiter (may drop any cycle)
//            bus_valid    out  a beat is on the bus this cycle
//            bus_data     out  [DATA_W-1:0] beat payload (0 when idle)
//            done         out  pulse with the final beat of a burst
//            timeout_err  out  pulse when a command is aborted for no grant
//            busy         out  engine active or commands queued
//
// Revision : 1.0 - initial release
// ============================================================================
module arbiter_requester #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 15,
    parameter int GAP        = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [3:0]        cmd_len,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              REQ,
    input  logic              GNT,
    output logic              bus_valid,
    output logic [DATA_W-1:0] bus_data,
    output logic              done,
    output logic              timeout_err,
    output logic              busy
);

    // ------------------------------------------------------------------------
    // Derived widths and constants
    // ------------------------------------------------------------------------
    localparam int C_PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int C_CNT_W   = $clog2(FIFO_DEPTH + 1);
    localparam int C_ENTRY_W = 4 + DATA_W;
    // Wait counter only needs to reach TIMEOUT-1; gap counter only GAP-1.
    localparam int C_WAIT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int C_GAP_W   = (GAP > 1) ? $clog2(GAP) : 1;

    localparam logic [C_PTR_W-1:0]  C_PTR_LAST  = C_PTR_W'(FIFO_DEPTH - 1);
    localparam logic [C_CNT_W-1:0]  C_CNT_FULL  = C_CNT_W'(FIFO_DEPTH);
    localparam logic [C_WAIT_W-1:0] C_WAIT_LAST = C_WAIT_W'(TIMEOUT - 1);
    localparam logic [C_GAP_W-1:0]  C_GAP_LAST  = C_GAP_W'(GAP - 1);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_REQ_WAIT = 2'd1,
        ST_XFER     = 2'd2,
        ST_GAP      = 2'd3
    } state_t;

    // With GAP=0 a finished or aborted transaction returns directly to IDLE.
    localparam state_t C_AFTER_TXN = (GAP == 0) ? ST_IDLE : ST_GAP;

    // ------------------------------------------------------------------------
    // Command FIFO
    // ------------------------------------------------------------------------
    logic [C_ENTRY_W-1:0] r_mem [FIFO_DEPTH];
    logic [C_PTR_W-1:0]   r_wr_ptr;
    logic [C_PTR_W-1:0]   r_rd_ptr;
    logic [C_CNT_W-1:0]   r_count;

    logic                 w_full;
    logic                 w_empty;
    logic                 w_push;
    logic                 w_pop;
    logic [C_ENTRY_W-1:0] w_head;
    logic [3:0]           w_head_len;
    logic [DATA_W-1:0]    w_head_data;

    state_t               r_state;
    state_t               w_next_state;

    function automatic logic [C_PTR_W-1:0] ptr_inc(input logic [C_PTR_W-1:0] p);
        if (p == C_PTR_LAST) begin
            return '0;
        end
        return p + C_PTR_W'(1);
    endfunction

    assign w_full      = (r_count == C_CNT_FULL);
    assign w_empty     = (r_count == '0);
    // Readiness depends on fullness only, so a full FIFO refuses a push even
    // in a cycle where the engine is popping the head.
    assign cmd_ready   = ~w_full;
    assign w_push      = cmd_valid & ~w_full;
    assign w_pop       = (r_state == ST_IDLE) & ~w_empty;

    assign w_head      = r_mem[r_rd_ptr];
    assign w_head_len  = w_head[C_ENTRY_W-1 -: 4];
    assign w_head_data = w_head[DATA_W-1:0];

    // Storage is never read while empty, so it needs no reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {cmd_len, cmd_data};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + C_CNT_W'(1);
                2'b01:   r_count <= r_count - C_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Working registers for the command in flight
    // ------------------------------------------------------------------------
    logic [3:0]          r_len;
    logic [DATA_W-1:0]   r_base;
    logic [3:0]          r_beat_idx;
    logic [C_WAIT_W-1:0] r_wait_cnt;
    logic [C_GAP_W-1:0]  r_gap_cnt;

    logic                w_req;
    logic                w_bus_valid;
    logic                w_done;
    logic                w_timeout;
    logic                w_wait_inc;
    logic                w_beat_inc;
    logic                w_gap_inc;

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next state and outputs
    // ------------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        w_req        = 1'b0;
        w_bus_valid  = 1'b0;
        w_done       = 1'b0;
        w_timeout    = 1'b0;
        w_wait_inc   = 1'b0;
        w_beat_inc   = 1'b0;
        w_gap_inc    = 1'b0;

        case (r_state)
            ST_IDLE: begin
                // GNT is ignored here; the head is popped into the working
                // registers on the same edge that moves us to REQ_WAIT.
                if (!w_empty) begin
                    w_next_state = ST_REQ_WAIT;
                end
            end

            ST_REQ_WAIT: begin
                w_req = 1'b1;
                if (GNT) begin
                    // The grant cycle itself carries no beat; data starts in XFER.
                    w_next_state = ST_XFER;
                end else if (r_wait_cnt == C_WAIT_LAST) begin
                    w_timeout    = 1'b1;
                    w_next_state = C_AFTER_TXN;
                end else begin
                    w_wait_inc = 1'b1;
                end
            end

            ST_XFER: begin
                // Losing GNT mid-burst is pre-emption, not a timeout: REQ stays
                // up and the beat index holds until the grant returns.
                w_req       = 1'b1;
                w_bus_valid = GNT;
                if (GNT) begin
                    if (r_beat_idx == r_len) begin
                        w_done       = 1'b1;
                        w_next_state = C_AFTER_TXN;
                    end else begin
                        w_beat_inc = 1'b1;
                    end
                end
            end

            ST_GAP: begin
                if (r_gap_cnt == C_GAP_LAST) begin
                    w_next_state = ST_IDLE;
                end else begin
                    w_gap_inc = 1'b1;
                end
            end

            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Working register updates
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_len      <= '0;
            r_base     <= '0;
            r_beat_idx <= '0;
            r_wait_cnt <= '0;
            r_gap_cnt  <= '0;
        end else begin
            if (w_pop) begin
                r_len      <= w_head_len;
                r_base     <= w_head_data;
                r_beat_idx <= '0;
                r_wait_cnt <= '0;
            end else begin
                if (w_wait_inc) begin
                    r_wait_cnt <= r_wait_cnt + C_WAIT_W'(1);
                end
                if (w_beat_inc) begin
                    r_beat_idx <= r_beat_idx + 4'd1;
                end
            end
            // The gap counter is held at zero outside GAP so each gap starts fresh.
            if (w_gap_inc) begin
                r_gap_cnt <= r_gap_cnt + C_GAP_W'(1);
            end else begin
                r_gap_cnt <= '0;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign REQ         = w_req;
    assign bus_valid   = w_bus_valid;
    // Payload is forced to zero whenever no beat is presented.
    assign bus_data    = w_bus_valid ? (r_base + DATA_W'(r_beat_idx)) : '0;
    assign done        = w_done;
    assign timeout_err = w_timeout;
    assign busy        = (r_state != ST_IDLE) | ~w_empty;

endmodule
`default_nettype wire

// File: tb/tb_arbiter_requester.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_arbiter_requester
// Purpose  : Self-checking bench for arbiter_requester. A scoreboard queue
//            holds the beats each accepted command must produce; beats are
//            popped and compared as the DUT presents them. The arbiter is
//            modelled as a grant that follows REQ after a programmable number
//            of cycles, with optional forced drops.
// Revision : 1.0 - initial release
// ============================================================================
module tb_arbiter_requester;

    localparam int DATA_W = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [3:0]        cmd_len;
    logic [DATA_W-1:0] cmd_data;
    logic              REQ;
    logic              GNT;
    logic              bus_valid;
    logic [DATA_W-1:0] bus_data;
    logic              done;
    logic              timeout_err;
    logic              busy;

    always #5 clk = ~clk;

    arbiter_requester #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (4),
        .TIMEOUT    (15),
        .GAP        (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_len     (cmd_len),
        .cmd_data    (cmd_data),
        .REQ         (REQ),
        .GNT         (GNT),
        .bus_valid   (bus_valid),
        .bus_data    (bus_data),
        .done        (done),
        .timeout_err (timeout_err),
        .busy        (busy)
    );

    int tests = 0;
    int fails = 0;

    // Scoreboard entries: {last_beat, data}
    logic [DATA_W:0] exp_q[$];
    bit  expect_beats = 1'b1;

    // Arbiter model controls
    bit  gnt_en    = 1'b0;
    int  gnt_delay = 1;
    int  drop_left = 0;
    int  req_run   = 0;

    // Per-cycle samples and running totals
    logic              s_req, s_valid, s_done, s_to, s_busy, s_ready;
    logic [DATA_W-1:0] s_data;
    int                to_total   = 0;
    int                done_total = 0;

    // One clock cycle: record any accepted command, advance, drive GNT,
    // sample outputs and check beats against the scoreboard.
    task automatic tick();
        logic [DATA_W:0] e;
        if (cmd_valid && cmd_ready && expect_beats) begin
            for (int i = 0; i <= int'(cmd_len); i++) begin
                exp_q.push_back({(i == int'(cmd_len)), DATA_W'(cmd_data + DATA_W'(i))});
            end
        end
        @(posedge clk);
        #1;
        GNT = gnt_en && (req_run >= gnt_delay) && (drop_left == 0);
        if (drop_left > 0) drop_left--;
        #1;
        s_req   = REQ;
        s_valid = bus_valid;
        s_data  = bus_data;
        s_done  = done;
        s_to    = timeout_err;
        s_busy  = busy;
        s_ready = cmd_ready;
        req_run = REQ ? req_run + 1 : 0;
        if (done)        done_total++;
        if (timeout_err) to_total++;
        if (bus_valid) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_beat: got data=%h, expected no beat", bus_data);
            end else begin
                e = exp_q.pop_front();
                if (bus_data !== e[DATA_W-1:0] || done !== e[DATA_W]) begin
                    fails++;
                    $display("FAIL beat: got data=%h done=%b, expected data=%h done=%b",
                             bus_data, done, e[DATA_W-1:0], e[DATA_W]);
                end
            end
        end else if (done) begin
            tests++;
            fails++;
            $display("FAIL done_without_beat: got done=1 bus_valid=0, expected done only with a beat");
        end
        if (done || timeout_err) begin
            tests++;
            if (done && timeout_err) begin
                fails++;
                $display("FAIL done_timeout_overlap: got both=1, expected exclusive");
            end
        end
    endtask

    task automatic wait_idle(input string name, input int max);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while ((s_busy || exp_q.size() != 0) && n < max);
        tests++;
        if (s_busy || exp_q.size() != 0) begin
            fails++;
            $display("FAIL %s_idle: got busy=%b pending=%0d after %0d cycles, expected busy=0 pending=0",
                     name, s_busy, exp_q.size(), n);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; cmd_valid = 1'b0; cmd_len = '0; cmd_data = '0; GNT = 1'b0;
        gnt_en = 1'b0;
        repeat (3) tick();
        tests++;
        if ({REQ, bus_valid, bus_data, done, timeout_err, busy, cmd_ready} !==
            {1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            fails++;
            $display("FAIL reset_during: got REQ=%b bv=%b bd=%h done=%b to=%b busy=%b rdy=%b, expected 0 0 00 0 0 0 1",
                     REQ, bus_valid, bus_data, done, timeout_err, busy, cmd_ready);
        end
        reset = 1'b0;
        repeat (2) tick();
        tests++;
        if ({REQ, bus_valid, bus_data, done, timeout_err, busy, cmd_ready} !==
            {1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            fails++;
            $display("FAIL reset_after: got REQ=%b bv=%b bd=%h done=%b to=%b busy=%b rdy=%b, expected 0 0 00 0 0 0 1",
                     REQ, bus_valid, bus_data, done, timeout_err, busy, cmd_ready);
        end
    endtask

    task automatic test_basic();
        int beats, n;
        gnt_en = 1'b1; gnt_delay = 1;
        cmd_valid = 1'b1; cmd_len = 4'd3; cmd_data = 8'h10;
        tick();
        cmd_valid = 1'b0;
        tests++;
        if (s_req !== 1'b0) begin
            fails++;
            $display("FAIL basic_req_early: got REQ=%b one cycle after push, expected 0", s_req);
        end
        tick();
        tests++;
        if (s_req !== 1'b1) begin
            fails++;
            $display("FAIL basic_req_rise: got REQ=%b two cycles after push, expected 1", s_req);
        end
        beats = 0; n = 0;
        do begin
            tick();
            n++;
            if (s_valid) beats++;
        end while (!s_done && n < 20);
        tests++;
        if (beats != 4 || n != 5) begin
            fails++;
            $display("FAIL basic_burst: got beats=%0d cycles=%0d, expected beats=4 cycles=5", beats, n);
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            tests++;
            if (s_req !== 1'b0 || s_busy !== 1'b1) begin
                fails++;
                $display("FAIL basic_gap%0d: got REQ=%b busy=%b, expected REQ=0 busy=1", i, s_req, s_busy);
            end
        end
        wait_idle("basic", 3);
    endtask

    task automatic test_preempt();
        int phase, gap_cyc, gap_req, beats, n, to0;
        gnt_en = 1'b1; gnt_delay = 1;
        to0 = to_total;
        cmd_valid = 1'b1; cmd_len = 4'd3; cmd_data = 8'h10;
        tick();
        cmd_valid = 1'b0;
        phase = 0; gap_cyc = 0; gap_req = 0; beats = 0; n = 0;
        do begin
            tick();
            n++;
            if (s_valid) beats++;
            if (phase == 1 && !s_valid) begin
                gap_cyc++;
                if (s_req) gap_req++;
            end
            if (s_valid && s_data == 8'h11 && phase == 0) begin
                phase = 1;
                drop_left = 3;
            end else if (s_valid && s_data == 8'h12) begin
                phase = 2;
            end
        end while (!s_done && n < 40);
        tests++;
        if (gap_cyc != 3 || gap_req != 3 || beats != 4 || to_total != to0) begin
            fails++;
            $display("FAIL preempt: got gap=%0d req_in_gap=%0d beats=%0d timeouts=%0d, expected 3 3 4 0",
                     gap_cyc, gap_req, beats, to_total - to0);
        end
        wait_idle("preempt", 10);
    endtask

    task automatic test_timeout();
        logic req_h[25], busy_h[25], to_h[25];
        int req_cnt, to_cnt, val_cnt, t;
        gnt_en = 1'b0;
        expect_beats = 1'b0;
        cmd_valid = 1'b1; cmd_len = 4'd0; cmd_data = 8'h55;
        tick();
        cmd_valid = 1'b0;
        req_cnt = 0; to_cnt = 0; val_cnt = 0; t = -1;
        for (int i = 0; i < 25; i++) begin
            tick();
            req_h[i] = s_req; busy_h[i] = s_busy; to_h[i] = s_to;
            if (s_req)   req_cnt++;
            if (s_valid) val_cnt++;
            if (s_to) begin
                to_cnt++;
                t = i;
            end
        end
        tests++;
        if (req_cnt != 15 || to_cnt != 1 || val_cnt != 0) begin
            fails++;
            $display("FAIL timeout_counts: got req_cycles=%0d pulses=%0d beats=%0d, expected 15 1 0",
                     req_cnt, to_cnt, val_cnt);
        end
        tests++;
        if (t < 0 || t > 21) begin
            fails++;
            $display("FAIL timeout_seen: got pulse index=%0d, expected a pulse within window", t);
        end else if (!(req_h[t] && to_h[t] && !req_h[t+1] && busy_h[t+1] &&
                       !req_h[t+2] && busy_h[t+2] && !busy_h[t+3])) begin
            fails++;
            $display("FAIL timeout_gap: got req=%b%b%b busy=%b%b%b, expected req=100 busy=110",
                     req_h[t], req_h[t+1], req_h[t+2], busy_h[t+1], busy_h[t+2], busy_h[t+3]);
        end
        expect_beats = 1'b1;
    endtask

    task automatic test_timeout_edge();
        int to0, d0;
        // Grant on the last allowed waiting cycle: transfer proceeds.
        gnt_en = 1'b1; gnt_delay = 14;
        to0 = to_total; d0 = done_total;
        cmd_valid = 1'b1; cmd_len = 4'd1; cmd_data = 8'h70;
        tick();
        cmd_valid = 1'b0;
        wait_idle("edge14", 60);
        tests++;
        if (to_total != to0 || done_total != d0 + 1) begin
            fails++;
            $display("FAIL timeout_edge14: got timeouts=%0d dones=%0d, expected 0 1",
                     to_total - to0, done_total - d0);
        end
        // Grant one cycle too late: command is aborted.
        gnt_delay = 15;
        expect_beats = 1'b0;
        to0 = to_total; d0 = done_total;
        cmd_valid = 1'b1; cmd_len = 4'd0; cmd_data = 8'h71;
        tick();
        cmd_valid = 1'b0;
        wait_idle("edge15", 60);
        tests++;
        if (to_total != to0 + 1 || done_total != d0) begin
            fails++;
            $display("FAIL timeout_edge15: got timeouts=%0d dones=%0d, expected 1 0",
                     to_total - to0, done_total - d0);
        end
        expect_beats = 1'b1;
        gnt_delay = 1;
    endtask

    task automatic test_back_to_back();
        logic [3:0]        lens [5];
        logic [DATA_W-1:0] dats [5];
        int d0, n;
        lens = '{4'd1, 4'd0, 4'd2, 4'd1, 4'd0};
        dats = '{8'hA0, 8'hB0, 8'hC0, 8'hD0, 8'hE0};
        gnt_en = 1'b1; gnt_delay = 1;
        d0 = done_total;
        // Long burst keeps the engine busy so the queue fills without pops.
        cmd_valid = 1'b1; cmd_len = 4'd15; cmd_data = 8'h80;
        tick();
        for (int i = 0; i < 4; i++) begin
            cmd_len = lens[i]; cmd_data = dats[i];
            tests++;
            if (cmd_ready !== 1'b1) begin
                fails++;
                $display("FAIL b2b_ready%0d: got cmd_ready=%b, expected 1", i, cmd_ready);
            end
            tick();
        end
        cmd_len = lens[4]; cmd_data = dats[4];
        tests++;
        if (cmd_ready !== 1'b0) begin
            fails++;
            $display("FAIL b2b_full: got cmd_ready=%b with 4 queued, expected 0", cmd_ready);
        end
        n = 0;
        while (!cmd_ready && n < 60) begin
            tick();
            n++;
        end
        tests++;
        if (!cmd_ready) begin
            fails++;
            $display("FAIL b2b_accept5: got cmd_ready=0 after %0d cycles, expected a slot", n);
        end
        tick();
        cmd_valid = 1'b0;
        wait_idle("b2b", 200);
        tests++;
        if (done_total != d0 + 6) begin
            fails++;
            $display("FAIL b2b_dones: got %0d, expected 6", done_total - d0);
        end
    endtask

    task automatic test_wrap();
        int n;
        logic [DATA_W-1:0] last;
        gnt_en = 1'b1; gnt_delay = 1;
        cmd_valid = 1'b1; cmd_len = 4'd3; cmd_data = 8'hFE;
        tick();
        cmd_valid = 1'b0;
        n = 0; last = '0;
        do begin
            tick();
            n++;
            if (s_done) last = s_data;
        end while (!s_done && n < 20);
        tests++;
        if (!s_done || last !== 8'h01) begin
            fails++;
            $display("FAIL wrap_last: got done=%b data=%h, expected done=1 data=01", s_done, last);
        end
        wait_idle("wrap", 10);
    endtask

    task automatic test_reset_mid();
        int n, vcnt, rcnt;
        gnt_en = 1'b1; gnt_delay = 1;
        cmd_valid = 1'b1; cmd_len = 4'd3;
        cmd_data = 8'h20; tick();
        cmd_data = 8'h30; tick();
        cmd_data = 8'h40; tick();
        cmd_valid = 1'b0;
        n = 0;
        while (!(s_valid && s_data == 8'h21) && n < 30) begin
            tick();
            n++;
        end
        tests++;
        if (!(s_valid && s_data == 8'h21)) begin
            fails++;
            $display("FAIL rmid_beat2: got no beat 21 within %0d cycles, expected it", n);
        end
        exp_q.delete();
        reset = 1'b1;
        tick();
        tests++;
        if ({REQ, bus_valid, bus_data, busy, cmd_ready, done} !== {1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0}) begin
            fails++;
            $display("FAIL rmid_reset: got REQ=%b bv=%b bd=%h busy=%b rdy=%b done=%b, expected 0 0 00 0 1 0",
                     REQ, bus_valid, bus_data, busy, cmd_ready, done);
        end
        tick();
        reset = 1'b0;
        vcnt = 0; rcnt = 0;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (s_valid) vcnt++;
            if (s_req)   rcnt++;
        end
        tests++;
        if (vcnt != 0 || rcnt != 0 || s_busy !== 1'b0) begin
            fails++;
            $display("FAIL rmid_after: got beats=%0d req_cycles=%0d busy=%b, expected 0 0 0", vcnt, rcnt, s_busy);
        end
    endtask

    initial begin
        reset = 1'b1; cmd_valid = 1'b0; cmd_len = '0; cmd_data = '0; GNT = 1'b0;
        test_reset();
        test_basic();
        test_preempt();
        test_timeout();
        test_timeout_edge();
        test_back_to_back();
        test_wrap();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
